pcileech_bar_cpl_gen: RTL

- Converts BAR read responses into PCIe completion TLPs.
- Inputs are the `rd_rsp_ctx`/`rd_rsp_data`/`rd_rsp_valid` outputs of a BAR implementation block.
- Buffers responses in a small FIFO and emits each completion as a 32-bit dword stream with valid/ready, sop and eop, toward the TLP transmit arbiter.
- This is the transmit-side counterpart to the BAR implementation's read-reply interface.

---
 rtl/pcileech_bar_cpl_gen_if.sv | 22 ++
 rtl/pcileech_bar_cpl_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pcileech_bar_cpl_gen_if.sv
// BAR read-response input and completion TLP dword stream bundled for pcileech_bar_cpl_gen.
// master = completion generator side, slave = response source / TLP sink side.
interface pcileech_bar_cpl_gen_if;
  logic [87:0] rd_rsp_ctx;
  logic [31:0] rd_rsp_data;
  logic        rd_rsp_valid;
  logic [31:0] tlp_data;
  logic        tlp_sop;
  logic        tlp_eop;
  logic        tlp_valid;
  logic        tlp_ready;

  modport master (
    input  rd_rsp_ctx, rd_rsp_data, rd_rsp_valid, tlp_ready,
    output tlp_data, tlp_sop, tlp_eop, tlp_valid
  );

  modport slave (
    output rd_rsp_ctx, rd_rsp_data, rd_rsp_valid, tlp_ready,
    input  tlp_data, tlp_sop, tlp_eop, tlp_valid
  );
endinterface

// File: rtl/pcileech_bar_cpl_gen.sv
// Turns BAR read responses into CplD TLPs (4 dwords) through a small response FIFO.
// Optional macro CPLGEN_UR_EN: entries flagged UR become 3-dword Cpl with UR status.
module pcileech_bar_cpl_gen #(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           completer_id,
  pcileech_bar_cpl_gen_if.master bus,
  input  logic                  ovf_clr,
  output logic                  ovf_sticky,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, H0, H1, H2, D} state_t;

  // Field order mirrors ctx[36:0] so a response packs straight in.
  typedef struct packed {
    logic        ur;
    logic [1:0]  attr;
    logic [2:0]  tc;
    logic [6:0]  lo_addr;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, drop, more;
  state_t        state, state_nxt;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign pop   = bus.tlp_valid & bus.tlp_ready & bus.tlp_eop;
  assign push  = bus.rd_rsp_valid & (~full | pop);
  assign drop  = bus.rd_rsp_valid & full & ~pop;
  // On an eop pop, any strobe this cycle is always stored, so the FIFO is non-empty next cycle.
  assign more  = (count > (AW+1)'(1)) | bus.rd_rsp_valid;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.rd_rsp_ctx[87:37], head.ur};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.rd_rsp_ctx[36:0], bus.rd_rsp_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A same-cycle drop beats the clear so the new loss is not hidden.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (ovf_clr)          drop_count <= DROP_CNT_W'(1);
      else if (~&drop_count) drop_count <= drop_count + 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      drop_count <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  logic [31:0] hdr0_cpld, hdr1_cpld, hdr2;
  assign hdr0_cpld = {3'b010, 5'b01010, 1'b0, head.tc, 4'b0, 2'b00, head.attr, 2'b00, 10'd1};
  assign hdr1_cpld = {completer_id, 3'b000, 1'b0, 12'd4};
  assign hdr2      = {head.req_id, head.tag, 1'b0, head.lo_addr};

`ifdef CPLGEN_UR_EN
  logic [31:0] hdr0_ur, hdr1_ur;
  assign hdr0_ur = {3'b000, 5'b01010, 1'b0, head.tc, 4'b0, 2'b00, head.attr, 2'b00, 10'd0};
  assign hdr1_ur = {completer_id, 3'b001, 1'b0, 12'd4};
`endif

  // Outputs come straight from state and FIFO head, both frozen while stalled.
  always_comb begin
    state_nxt     = state;
    bus.tlp_valid = 1'b0;
    bus.tlp_sop   = 1'b0;
    bus.tlp_eop   = 1'b0;
    bus.tlp_data  = '0;
    case (state)
      IDLE: if (!empty) state_nxt = H0;
      H0: begin
        bus.tlp_valid = 1'b1;
        bus.tlp_sop   = 1'b1;
`ifdef CPLGEN_UR_EN
        bus.tlp_data  = head.ur ? hdr0_ur : hdr0_cpld;
`else
        bus.tlp_data  = hdr0_cpld;
`endif
        if (bus.tlp_ready) state_nxt = H1;
      end
      H1: begin
        bus.tlp_valid = 1'b1;
`ifdef CPLGEN_UR_EN
        bus.tlp_data  = head.ur ? hdr1_ur : hdr1_cpld;
`else
        bus.tlp_data  = hdr1_cpld;
`endif
        if (bus.tlp_ready) state_nxt = H2;
      end
      H2: begin
        bus.tlp_valid = 1'b1;
        bus.tlp_data  = hdr2;
`ifdef CPLGEN_UR_EN
        bus.tlp_eop   = head.ur;
        if (bus.tlp_ready) state_nxt = head.ur ? (more ? H0 : IDLE) : D;
`else
        if (bus.tlp_ready) state_nxt = D;
`endif
      end
      D: begin
        bus.tlp_valid = 1'b1;
        bus.tlp_eop   = 1'b1;
        bus.tlp_data  = head.data;
        if (bus.tlp_ready) state_nxt = more ? H0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
